// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of NUM_FIFOS registered-read FIFOs into one egress push port; push lags pop by 1 cycle.
// Pops stop on dest_almost_full or enable low; define DRAIN_COUNT_EN for the saturating pop_count port.
module fifo_drain_arbiter #(
   parameter int NUM_FIFOS      = 8,
   parameter int FIFO_WORD_SIZE = 10,
   parameter int SEL_SIZE       = $clog2(NUM_FIFOS)
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic [NUM_FIFOS-1:0]                FIFOs_empty,
   input  logic [NUM_FIFOS*FIFO_WORD_SIZE-1:0] FIFOs_data_out,
   input  logic                                dest_almost_full,
   output logic [NUM_FIFOS-1:0]                FIFOs_pop,
   output logic                                dest_push,
   output logic [FIFO_WORD_SIZE-1:0]           dest_data,
   output logic [SEL_SIZE-1:0]                 dest_sel,
   output logic                                busy
`ifdef DRAIN_COUNT_EN
   ,
   output logic [15:0]                         pop_count
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      RUN   = 3'b010,
      STALL = 3'b100
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SEL_SIZE-1:0] rr_ptr;
   logic [SEL_SIZE-1:0] grant;
   logic                grant_found;
   logic                all_empty;
   logic                pop_vld;
   logic [SEL_SIZE:0]   cand;

   assign all_empty = &FIFOs_empty;

   // Search rr_ptr+1, rr_ptr+2, ... with wrap; cand is one bit wider so the sum never overflows.
   always_comb begin
      grant       = rr_ptr;
      grant_found = 1'b0;
      cand        = '0;
      for (int k = 1; k <= NUM_FIFOS; k++) begin
         cand = {1'b0, rr_ptr} + (SEL_SIZE+1)'(k);
         if (cand >= (SEL_SIZE+1)'(NUM_FIFOS))
            cand = cand - (SEL_SIZE+1)'(NUM_FIFOS);
         if (!grant_found && !FIFOs_empty[cand[SEL_SIZE-1:0]]) begin
            grant       = cand[SEL_SIZE-1:0];
            grant_found = 1'b1;
         end
      end
   end

   // Gating on enable and almost_full makes the pop stop in the same cycle the FSM leaves RUN.
   assign pop_vld = (state == RUN) && enable && !dest_almost_full && grant_found;

   always_comb begin
      FIFOs_pop        = '0;
      FIFOs_pop[grant] = pop_vld;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (enable && !all_empty)
               state_nxt = dest_almost_full ? STALL : RUN;
         end
         RUN: begin
            if (!enable || all_empty)
               state_nxt = IDLE;
            else if (dest_almost_full)
               state_nxt = STALL;
         end
         STALL: begin
            if (!enable)
               state_nxt = IDLE;
            else if (!dest_almost_full)
               state_nxt = all_empty ? IDLE : RUN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rr_ptr    <= SEL_SIZE'(NUM_FIFOS - 1);
         dest_push <= 1'b0;
         dest_sel  <= '0;
      end else begin
         state     <= state_nxt;
         dest_push <= pop_vld;
         if (pop_vld) begin
            rr_ptr   <= grant;
            dest_sel <= grant;
         end
      end
   end

   // Input FIFOs present read data the cycle after the pop, aligned with dest_push.
   assign dest_data = dest_push ? FIFOs_data_out[dest_sel*FIFO_WORD_SIZE +: FIFO_WORD_SIZE]
                                : '0;

   assign busy = (state != IDLE) || dest_push;

`ifdef DRAIN_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         pop_count <= '0;
      else if (dest_push && (pop_count != 16'hFFFF))
         pop_count <= pop_count + 16'd1;
   end
`endif

   a_pop_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(FIFOs_pop));
   a_pop_not_empty : assert property (@(posedge clk) disable iff (reset)
                                      (FIFOs_pop & FIFOs_empty) == '0);

endmodule
